// File: rtl/cam_seq_pkg.sv
// Shared definitions for the camera power sequencer: state encoding, state
// field width and default phase timings.
package cam_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF     = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_CLKON   = 3'd2,
        ST_RSTHOLD = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_READY   = 3'd5,
        ST_PWRDN   = 3'd6
    } cam_state_e;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_T_PWDN   = 1000;
    localparam int DEF_T_CLK    = 100;
    localparam int DEF_T_RST    = 500;
    localparam int DEF_T_SETTLE = 20000;
    localparam int DEF_WD_W     = 24;
    localparam int DEF_T_WDOG   = 1000000;

endpackage

// File: rtl/cam_seq_timer.sv
// Loadable down-counter shared by all timed phases of the sequencer; stops at
// zero and flags it.
module cam_seq_timer
    import cam_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up/power-down sequencer (mclk domain). Define CAM_PWR_SEQ_WDOG_EN
// to add the vsync watchdog that forces a fault and a full re-sequence.
module cam_pwr_seq
    import cam_seq_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_PWDN   = DEF_T_PWDN,
    parameter int T_CLK    = DEF_T_CLK,
    parameter int T_RST    = DEF_T_RST,
    parameter int T_SETTLE = DEF_T_SETTLE,
    parameter int WD_W     = DEF_WD_W,
    parameter int T_WDOG   = DEF_T_WDOG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               power_on_req,
    input  logic               cam_vsync,
    output logic               cam_pwdn,
    output logic               cam_clk_en,
    output logic               cam_rst_n,
    output logic               cam_ready,
    output logic               busy,
    output logic [STATE_W-1:0] state,
    output logic               fault
);

    localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(T_PWDN - 1);
    localparam logic [CNT_W-1:0] LD_CLK    = CNT_W'(T_CLK - 1);
    localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE - 1);

    cam_state_e state_q, state_d;
    logic       pwdn_q, pwdn_d;
    logic       clk_en_q, clk_en_d;
    logic       rst_n_q, rst_n_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             wd_trip;

    cam_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef CAM_PWR_SEQ_WDOG_EN
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(T_WDOG - 1);

    logic            vs_s1_q, vs_s2_q, vs_s3_q;
    logic            vs_rise;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign vs_rise = vs_s2_q & ~vs_s3_q;
    assign wd_trip = (state_q == ST_READY) && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if ((state_q != ST_READY) || vs_rise) begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            vs_s3_q  <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            vs_s1_q  <= cam_vsync;
            vs_s2_q  <= vs_s1_q;
            vs_s3_q  <= vs_s2_q;
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = cam_vsync;
    assign wd_trip      = 1'b0;
`endif

    always_comb begin
        logic down_req;
        state_d  = state_q;
        pwdn_d   = pwdn_q;
        clk_en_d = clk_en_q;
        rst_n_d  = rst_n_q;
        ready_d  = ready_q;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        down_req = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (power_on_req) begin
                    state_d  = ST_PWRUP;
                    pwdn_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PWDN;
                end else begin
                    fault_d = 1'b0;
                end
            end
            ST_PWRUP: begin
                if (tmr_zero) begin
                    state_d  = ST_CLKON;
                    clk_en_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_CLK;
                end
            end
            ST_CLKON: begin
                if (tmr_zero) begin
                    state_d  = ST_RSTHOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end
            end
            ST_RSTHOLD: begin
                if (tmr_zero) begin
                    state_d  = ST_SETTLE;
                    rst_n_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                if (wd_trip) begin
                    fault_d  = 1'b1;
                    down_req = 1'b1;
                end
            end
            ST_PWRDN: begin
                if (tmr_zero) begin
                    state_d  = ST_OFF;
                    clk_en_d = 1'b0;
                    pwdn_d   = 1'b1;
                end
            end
            default: down_req = 1'b1;
        endcase

        // A dropped request overrides whatever the timed phase wanted this edge.
        if ((state_q inside {ST_PWRUP, ST_CLKON, ST_RSTHOLD, ST_SETTLE, ST_READY})
            && !power_on_req) begin
            down_req = 1'b1;
        end

        if (down_req) begin
            state_d  = ST_PWRDN;
            ready_d  = 1'b0;
            rst_n_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LD_CLK;
        end

        busy_d = !(state_d inside {ST_OFF, ST_READY});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_OFF;
            pwdn_q   <= 1'b1;
            clk_en_q <= 1'b0;
            rst_n_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwdn_q   <= pwdn_d;
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign state      = state_q;
    assign cam_pwdn   = pwdn_q;
    assign cam_clk_en = clk_en_q;
    assign cam_rst_n  = rst_n_q;
    assign cam_ready  = ready_q;
    assign busy       = busy_q;

`ifdef CAM_PWR_SEQ_WDOG_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_q ^ fault_d;
`endif

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with short phase timings (4/2/3/5, watchdog 8).
module tb_cam_pwr_seq;

    logic       clk;
    logic       reset;
    logic       power_on_req;
    logic       cam_vsync;
    logic       cam_pwdn;
    logic       cam_clk_en;
    logic       cam_rst_n;
    logic       cam_ready;
    logic       busy;
    logic [2:0] state;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit vs_en = 1'b0;

    cam_pwr_seq #(
        .CNT_W    (16),
        .T_PWDN   (4),
        .T_CLK    (2),
        .T_RST    (3),
        .T_SETTLE (5),
        .WD_W     (24),
        .T_WDOG   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .power_on_req (power_on_req),
        .cam_vsync    (cam_vsync),
        .cam_pwdn     (cam_pwdn),
        .cam_clk_en   (cam_clk_en),
        .cam_rst_n    (cam_rst_n),
        .cam_ready    (cam_ready),
        .busy         (busy),
        .state        (state),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; all sampling happens 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (vs_en) cam_vsync = ((cyc % 5) == 0);
        else       cam_vsync = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset        = 1'b1;
        power_on_req = 1'b0;
        cam_vsync    = 1'b0;
        steps(3);

        chk("rst_state", state, 0);
        chk("rst_pwdn", cam_pwdn, 1);
        chk("rst_clk_en", cam_clk_en, 0);
        chk("rst_rst_n", cam_rst_n, 0);
        chk("rst_ready", cam_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);

        reset = 1'b0;
        steps(2);
        chk("idle_state", state, 0);
        chk("idle_pwdn", cam_pwdn, 1);

        // Power-up: edge 0 is the first edge that samples the request.
        power_on_req = 1'b1;
        step();
        chk("pu_e0_state", state, 1);
        chk("pu_e0_pwdn", cam_pwdn, 0);
        chk("pu_e0_busy", busy, 1);
        for (int e = 1; e <= 14; e++) begin
            step();
            chk($sformatf("pu_e%0d_state", e), state,
                (e < 4) ? 1 : (e < 6) ? 2 : (e < 9) ? 3 : (e < 14) ? 4 : 5);
            chk($sformatf("pu_e%0d_clk_en", e), cam_clk_en, (e >= 4) ? 1 : 0);
            chk($sformatf("pu_e%0d_rst_n", e), cam_rst_n, (e >= 9) ? 1 : 0);
            chk($sformatf("pu_e%0d_ready", e), cam_ready, (e >= 14) ? 1 : 0);
            chk($sformatf("pu_e%0d_busy", e), busy, (e < 14) ? 1 : 0);
            chk($sformatf("pu_e%0d_pwdn", e), cam_pwdn, 0);
        end

        // Drop in READY.
        power_on_req = 1'b0;
        step();
        chk("drop_state0", state, 6);
        chk("drop_ready0", cam_ready, 0);
        chk("drop_rst_n0", cam_rst_n, 0);
        chk("drop_clk_en0", cam_clk_en, 1);
        chk("drop_pwdn0", cam_pwdn, 0);
        chk("drop_busy0", busy, 1);
        step();
        chk("drop_state1", state, 6);
        chk("drop_clk_en1", cam_clk_en, 1);
        step();
        chk("drop_state2", state, 0);
        chk("drop_clk_en2", cam_clk_en, 0);
        chk("drop_pwdn2", cam_pwdn, 1);
        chk("drop_busy2", busy, 0);

        // Abort in RSTHOLD, re-request one cycle later.
        power_on_req = 1'b1;
        steps(7);
        chk("ab_rsthold", state, 3);
        power_on_req = 1'b0;
        step();
        chk("ab_pwrdn0", state, 6);
        chk("ab_rst_n0", cam_rst_n, 0);
        power_on_req = 1'b1;
        step();
        chk("ab_pwrdn1", state, 6);
        chk("ab_clk_en1", cam_clk_en, 1);
        step();
        chk("ab_off", state, 0);
        chk("ab_off_pwdn", cam_pwdn, 1);
        step();
        chk("ab_restart", state, 1);
        chk("ab_restart_pwdn", cam_pwdn, 0);

        // Collision: request falls on the edge SETTLE expires.
        steps(13);
        chk("col_settle", state, 4);
        chk("col_ready_pre", cam_ready, 0);
        power_on_req = 1'b0;
        step();
        chk("col_state0", state, 6);
        chk("col_ready0", cam_ready, 0);
        step();
        chk("col_state1", state, 6);
        chk("col_ready1", cam_ready, 0);
        step();
        chk("col_state2", state, 0);
        chk("col_ready2", cam_ready, 0);

        // Asynchronous reset while in CLKON.
        power_on_req = 1'b1;
        steps(5);
        chk("ar_clkon", state, 2);
        chk("ar_clk_en_pre", cam_clk_en, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_state", state, 0);
        chk("ar_pwdn", cam_pwdn, 1);
        chk("ar_clk_en", cam_clk_en, 0);
        chk("ar_rst_n", cam_rst_n, 0);
        chk("ar_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        chk("ar_restart", state, 1);
        chk("ar_restart_pwdn", cam_pwdn, 0);
        steps(14);
        chk("ar_ready_state", state, 5);
        chk("ar_ready", cam_ready, 1);

`ifdef CAM_PWR_SEQ_WDOG_EN
        // No vsync: 8 cycles in READY then a fault and forced power-down.
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("wd_hold%0d", i), state, 5);
            chk($sformatf("wd_hold_fault%0d", i), fault, 0);
        end
        step();
        chk("wd_trip_state", state, 6);
        chk("wd_trip_fault", fault, 1);
        chk("wd_trip_ready", cam_ready, 0);
        steps(2);
        chk("wd_off", state, 0);
        step();
        chk("wd_reseq", state, 1);
        chk("wd_reseq_fault", fault, 1);
        steps(14);
        chk("wd_reready", state, 5);
        chk("wd_reready_flag", cam_ready, 1);
        power_on_req = 1'b0;
        steps(3);
        chk("wd_clr_off", state, 0);
        chk("wd_sticky", fault, 1);
        step();
        chk("wd_clr", fault, 0);

        // Regular vsync keeps the watchdog quiet.
        vs_en = 1'b1;
        power_on_req = 1'b1;
        steps(15);
        chk("vs_ready", state, 5);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("vs_state%0d", i), state, 5);
            chk($sformatf("vs_fault%0d", i), fault, 0);
        end
        vs_en = 1'b0;
`else
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("nowd_state%0d", i), state, 5);
            chk($sformatf("nowd_fault%0d", i), fault, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
